// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, reads one instruction per fetch over AR/R, and hands it to decode.
// Latency: 4 cycles REQ->REQ with an immediate memory, decode and commit side; one outstanding read.
// Backpressure: stalls on arready/rvalid/m_ready/npc_valid hold state and every output unchanged.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        WAIT_R   = 2'd1,
        SEND     = 2'd2,
        WAIT_NPC = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_err;

    // State register; reset returns to REQ from any state, including mid-transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; handshake outputs are forced low while rst is held
    // so a reset landing mid-transaction drops them in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            REQ: begin
                arvalid = ~rst;
                if (arready) begin
                    w_state_nxt = WAIT_R;
                end
            end
            WAIT_R: begin
                rready = ~rst;
                if (rvalid) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                m_valid = ~rst;
                if (m_ready) begin
                    w_state_nxt = WAIT_NPC;
                end
            end
            WAIT_NPC: begin
                if (npc_valid) begin
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = REQ;
            end
        endcase
    end

    // Datapath: capture read data only in WAIT_R, take the next PC only in WAIT_NPC.
    // The error flag is sticky; a bad response or misaligned PC never blocks the flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_inst <= 32'h0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == WAIT_R && rvalid) begin
                r_inst <= rdata;
                if (rresp != 2'b00) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == WAIT_NPC && npc_valid) begin
                r_pc <= npc;
                if (npc[1:0] != 2'b00) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign araddr    = r_pc;
    assign pcF       = r_pc;
    assign snpcF     = r_pc + 32'd4;
    assign instF     = r_inst;
    assign fetch_err = r_err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed fetch transactions with a decoupled scoreboard on the decode handshake.
// Stimulus is cycle-exact; per-cycle checks cover handshake exclusivity, stability and reset behaviour.
// The monitor pops one expected record per m_valid & m_ready and compares instF/pcF/snpcF/fetch_err.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h80000000;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic [31:0] snpcF;
    logic        m_valid;
    logic        m_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_err;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .instF     (instF),
        .pcF       (pcF),
        .snpcF     (snpcF),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .npc_valid (npc_valid),
        .npc       (npc),
        .fetch_err (fetch_err)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] snpc;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;
    logic        exp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per accepted decode handoff.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow actual=handoff required=none at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instF", instF, e.inst);
                chk("sb_pcF", pcF, e.pc);
                chk("sb_snpcF", snpcF, e.snpc);
                chk("sb_fetch_err", {31'h0, fetch_err}, {31'h0, e.err});
            end
        end
    end

    task automatic idle_inputs();
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        m_ready   = 1'b0;
        npc_valid = 1'b0;
        npc       = 32'h0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_arvalid"}, {31'h0, arvalid}, 32'h0);
        chk({tag, "_rready"}, {31'h0, rready}, 32'h0);
        chk({tag, "_m_valid"}, {31'h0, m_valid}, 32'h0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_quiet("rst");
            nxt();
        end
        @(negedge clk);
        chk("rst_instF", instF, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        chk("rst_pcF", pcF, RST_PC);
        chk("rst_snpcF", snpcF, 32'h80000004);
        nxt();
        rst     = 1'b0;
        exp_pc  = RST_PC;
        exp_err = 1'b0;
    endtask

    // One full fetch starting in REQ; returns with the DUT back in REQ at exp_pc.
    task automatic fetch_txn(input int ar_dly, input int r_dly, input logic early_rv,
                             input logic [31:0] data, input logic [1:0] resp,
                             input int m_dly, input logic junk_npc,
                             input int n_dly, input logic [31:0] nxt_pc);
        logic [31:0] snpc;
        exp_t        e;
        // REQ, arready stalled
        arready = 1'b0;
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            chk("req_arvalid", {31'h0, arvalid}, 32'h1);
            chk("req_araddr", araddr, exp_pc);
            chk("req_rready", {31'h0, rready}, 32'h0);
            chk("req_m_valid", {31'h0, m_valid}, 32'h0);
            nxt();
        end
        // AR handshake; optional junk R beat in the same cycle must not be taken
        arready = 1'b1;
        rvalid  = early_rv;
        rdata   = 32'hDEADBEEF;
        rresp   = 2'b11;
        @(negedge clk);
        chk("ar_arvalid", {31'h0, arvalid}, 32'h1);
        chk("ar_araddr", araddr, exp_pc);
        chk("ar_rready", {31'h0, rready}, 32'h0);
        chk("ar_err", {31'h0, fetch_err}, {31'h0, exp_err});
        nxt();
        arready = 1'b0;
        rvalid  = 1'b0;
        rresp   = 2'b00;
        // WAIT_R, rvalid delayed
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("wr_rready", {31'h0, rready}, 32'h1);
            chk("wr_arvalid", {31'h0, arvalid}, 32'h0);
            chk("wr_m_valid", {31'h0, m_valid}, 32'h0);
            nxt();
        end
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        @(negedge clk);
        chk("r_rready", {31'h0, rready}, 32'h1);
        nxt();
        rvalid = 1'b0;
        rdata  = 32'h0;
        rresp  = 2'b00;
        if (resp != 2'b00) exp_err = 1'b1;
        snpc = exp_pc + 32'd4;
        // SEND, decode stalled, stray npc pulses must be ignored
        m_ready = 1'b0;
        for (int i = 0; i < m_dly; i++) begin
            npc_valid = junk_npc && (i % 2 == 0);
            npc       = 32'h12345678;
            @(negedge clk);
            chk("snd_m_valid", {31'h0, m_valid}, 32'h1);
            chk("snd_instF", instF, data);
            chk("snd_pcF", pcF, exp_pc);
            chk("snd_snpcF", snpc, snpcF);
            chk("snd_arvalid", {31'h0, arvalid}, 32'h0);
            nxt();
        end
        npc_valid = 1'b0;
        e.inst = data;
        e.pc   = exp_pc;
        e.snpc = snpc;
        e.err  = exp_err;
        sb.push_back(e);
        m_ready = 1'b1;
        @(negedge clk);
        chk("snd_rready", {31'h0, rready}, 32'h0);
        nxt();
        m_ready = 1'b0;
        // WAIT_NPC
        for (int i = 0; i < n_dly; i++) begin
            @(negedge clk);
            chk_quiet("wn");
            chk("wn_pcF", pcF, exp_pc);
            nxt();
        end
        npc_valid = 1'b1;
        npc       = nxt_pc;
        @(negedge clk);
        chk_quiet("npc");
        nxt();
        npc_valid = 1'b0;
        npc       = 32'h0;
        exp_pc    = nxt_pc;
        if (nxt_pc[1:0] != 2'b00) exp_err = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        nxt();
        do_reset(2);

        // back-to-back immediate fetch, then stalls on every channel
        fetch_txn(0, 0, 1'b0, 32'h00000013, 2'b00, 0, 1'b0, 0, 32'h80000004);
        fetch_txn(5, 3, 1'b0, 32'h00100093, 2'b00, 0, 1'b0, 2, 32'h80000008);
        fetch_txn(0, 0, 1'b1, 32'h00208113, 2'b00, 4, 1'b1, 0, 32'h8000000C);
        // error response, then sticky across an OKAY fetch
        fetch_txn(0, 1, 1'b0, 32'hBADC0DE5, 2'b10, 1, 1'b0, 0, 32'h80000010);
        fetch_txn(1, 0, 1'b0, 32'h00000073, 2'b00, 0, 1'b0, 1, 32'hFFFFFFFC);
        @(negedge clk);
        chk("wrap_pcF", pcF, 32'hFFFFFFFC);
        chk("wrap_snpcF", snpcF, 32'h00000000);
        chk("sticky_err", {31'h0, fetch_err}, 32'h1);
        nxt();
        fetch_txn(0, 0, 1'b0, 32'h11111111, 2'b00, 0, 1'b0, 0, 32'h80000100);

        // reset in WAIT_R with a stale error beat on R
        arready = 1'b1;
        @(negedge clk);
        chk("rwr_araddr", araddr, 32'h80000100);
        nxt();
        arready = 1'b0;
        rst     = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'hFEEDFACE;
        rresp   = 2'b10;
        @(negedge clk);
        chk_quiet("rwr0");
        nxt();
        @(negedge clk);
        chk_quiet("rwr1");
        chk("rwr_instF", instF, 32'h0);
        chk("rwr_err", {31'h0, fetch_err}, 32'h0);
        chk("rwr_pcF", pcF, RST_PC);
        nxt();
        rst     = 1'b0;
        idle_inputs();
        exp_pc  = RST_PC;
        exp_err = 1'b0;

        // misaligned next PC: fetch still proceeds there, error flagged
        fetch_txn(0, 0, 1'b0, 32'h22222222, 2'b00, 0, 1'b0, 0, 32'h80000002);
        @(negedge clk);
        chk("mis_araddr", araddr, 32'h80000002);
        chk("mis_err", {31'h0, fetch_err}, 32'h1);
        nxt();
        fetch_txn(0, 0, 1'b0, 32'h33333333, 2'b00, 0, 1'b0, 0, 32'h80000040);

        // reset in SEND
        arready = 1'b1;
        @(negedge clk);
        nxt();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h44444444;
        @(negedge clk);
        nxt();
        rvalid = 1'b0;
        @(negedge clk);
        chk("rsd_m_valid_pre", {31'h0, m_valid}, 32'h1);
        chk("rsd_instF_pre", instF, 32'h44444444);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rsd0");
        nxt();
        @(negedge clk);
        chk_quiet("rsd1");
        chk("rsd_err", {31'h0, fetch_err}, 32'h0);
        chk("rsd_pcF", pcF, RST_PC);
        nxt();
        rst     = 1'b0;
        idle_inputs();
        exp_pc  = RST_PC;
        exp_err = 1'b0;
        fetch_txn(0, 0, 1'b0, 32'h55555555, 2'b00, 0, 1'b0, 0, 32'h80000004);

        repeat (2) nxt();
        chk("sb_drained", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the stimulus is cycle-exact, so this only trips if simulation stalls.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
